// File: rtl/mux_arbiter_2to1.sv
// mux_arbiter_2to1: two-lane FIFO-buffered arbiter driving a shared registered 2:1 mux path.
//   Build option: define MUX_ARB_PRIORITY_EN to make lane 0 always win; otherwise arbitration is round-robin.
//   Ports:
//     clk, reset            rising-edge clock, synchronous active-high reset
//     in0/valid_in0         lane 0 word and its strobe
//     in1/valid_in1         lane 1 word and its strobe
//     pause_in              downstream backpressure, blocks issue while high
//     pause0/pause1         lane FIFO occupancy at or above ALMOST_FULL
//     selector              lane granted on the most recent issue
//     data_out/valid_out    registered issued word and its valid
//     err0/err1             sticky flags for words dropped on a full lane FIFO
module mux_arbiter_2to1 #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int ALMOST_FULL = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic                  valid_in0,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic                  valid_in1,
    input  logic                  pause_in,
    output logic                  pause0,
    output logic                  pause1,
    output logic                  selector,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  err0,
    output logic                  err1
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {LAST0, LAST1} state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] mem [2][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] din [2];
    logic [AW-1:0]         wp [2];
    logic [AW-1:0]         rp [2];
    logic [CW-1:0]         cnt [2];
    logic [1:0]            ne, full, push, pop, err;
    logic                  gl, grant;

    assign din[0] = in0;
    assign din[1] = in1;
    assign pause0 = cnt[0] >= CW'(ALMOST_FULL);
    assign pause1 = cnt[1] >= CW'(ALMOST_FULL);
    assign err0   = err[0];
    assign err1   = err[1];

    always_comb begin
        ne    = {cnt[1] != '0, cnt[0] != '0};
        full  = {cnt[1] == CW'(FIFO_DEPTH), cnt[0] == CW'(FIFO_DEPTH)};
        push  = {valid_in1, valid_in0} & ~full;
        grant = !pause_in && (ne != 2'b00);
`ifdef MUX_ARB_PRIORITY_EN
        gl = !ne[0];
`else
        // Under contention serve the lane that did not win last time.
        gl = (ne == 2'b11) ? (state == LAST0) : !ne[0];
`endif
        pop        = grant ? (gl ? 2'b10 : 2'b01) : 2'b00;
        state_next = grant ? (gl ? LAST1 : LAST0) : state;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= LAST1;
        else state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                wp[i]  <= '0;
                rp[i]  <= '0;
                cnt[i] <= '0;
            end
            err       <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            selector  <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    mem[i][wp[i]] <= din[i];
                    wp[i]         <= wp[i] + AW'(1);
                end
                if (pop[i]) rp[i] <= rp[i] + AW'(1);
                cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
            end
            // A drop is judged on pre-edge fullness, so a same-edge pop does not rescue it.
            err       <= err | ({valid_in1, valid_in0} & full);
            valid_out <= grant;
            if (grant) begin
                data_out <= gl ? mem[1][rp[1]] : mem[0][rp[0]];
                selector <= gl;
            end
        end
    end
endmodule
